// File: rtl/booth2_digit_decoder.sv
// Rebuilds a signed multiplier from a stream of radix-4 Booth digits sent LSB-first.
// The running sum moves to DONE after the last digit and stays there until the consumer takes it.
module booth2_digit_decoder #(
  parameter int N_DIGITS = 16,
  parameter int W        = 2 * N_DIGITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_digit,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_value,
  output logic         out_err
);

  localparam int CNT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_DIGITS - 1);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_DONE  = 1'b1;

  logic [0:0]          state_q, state_d;
  logic signed [W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                err_q, err_d;
  logic                accept;
  logic                frame_end;

  function automatic logic digit_legal(input logic [2:0] d);
    case (d)
      3'b000, 3'b001, 3'b010, 3'b110, 3'b111: digit_legal = 1'b1;
      default:                                digit_legal = 1'b0;
    endcase
  endfunction

  // Illegal codes contribute nothing; legal ones are sign-extended and placed at 4^pos.
  function automatic logic signed [W-1:0] digit_weight(input logic [2:0]       d,
                                                       input logic [CNT_W-1:0] pos);
    logic signed [W-1:0] ext;
    ext = digit_legal(d) ? $signed({{(W-3){d[2]}}, d}) : '0;
    digit_weight = ext <<< {pos, 1'b0};
  endfunction

  assign accept    = in_valid && (state_q == ST_ACCUM);
  assign frame_end = in_last || (count_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    err_d   = err_q;
    if (state_q == ST_ACCUM) begin
      if (accept) begin
        acc_d   = acc_q + digit_weight(in_digit, count_q);
        count_d = count_q + CNT_W'(1);
        err_d   = err_q | ~digit_legal(in_digit);
        if (frame_end) state_d = ST_DONE;
      end
    end else if (out_ready) begin
      state_d = ST_ACCUM;
      acc_d   = '0;
      count_d = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign out_value = $unsigned(acc_q);
  assign out_err   = err_q;

endmodule

// File: tb/tb_booth2_digit_decoder.sv
// Bench for booth2_digit_decoder: frames are driven digit by digit, expected results are
// queued at drive time and compared when the output handshake occurs.
module tb_booth2_digit_decoder;

  localparam int ND = 16;
  localparam int W  = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_digit;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_value;
  logic         out_err;

  int checks   = 0;
  int failures = 0;

  logic [W:0]   exp_q[$];
  logic [2:0]   frame_d [ND];

  booth2_digit_decoder #(.N_DIGITS(ND), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_digit  (in_digit),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: arithmetic sum of digit * 4^i, illegal codes count as 0 and flag the frame.
  function automatic logic [W:0] model(input int n);
    longint sum;
    logic   e;
    longint sd;
    sum = 0;
    e   = 1'b0;
    for (int i = 0; i < n; i++) begin
      case (frame_d[i])
        3'b000: sd = 0;
        3'b001: sd = 1;
        3'b010: sd = 2;
        3'b110: sd = -2;
        3'b111: sd = -1;
        default: begin sd = 0; e = 1'b1; end
      endcase
      sum = sum + sd * (longint'(1) << (2 * i));
    end
    model = {e, sum[W-1:0]};
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", 64'(out_valid), 64'(0));
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        chk("sb_value", 64'(out_value), 64'(e[W-1:0]));
        chk("sb_err",   64'(out_err),   64'(e[W]));
      end
    end
  end

  task automatic clear_frame();
    for (int i = 0; i < ND; i++) frame_d[i] = 3'b000;
  endtask

  // Drives n digits back-to-back; in_last is raised on the final one when use_last is set.
  task automatic send_frame(input int n, input logic use_last, input logic push);
    if (push) exp_q.push_back(model(n));
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_digit = frame_d[i];
      in_last  = use_last && (i == n - 1);
      chk("in_ready_accum", 64'(in_ready), 64'(1));
      @(posedge clk); #1;
      if (push) chk(i == n - 1 ? "lat_done" : "lat_accum", 64'(out_valid), 64'(i == n - 1));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic consume(input int stall);
    logic [W-1:0] v0;
    logic         e0;
    v0 = out_value;
    e0 = out_err;
    in_valid = 1'b1;
    in_digit = 3'b111;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      chk("stall_ready", 64'(in_ready),  64'(0));
      chk("stall_valid", 64'(out_valid), 64'(1));
      chk("stall_value", 64'(out_value), 64'(v0));
      chk("stall_err",   64'(out_err),   64'(e0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("post_hs_ready", 64'(in_ready),  64'(1));
    chk("post_hs_valid", 64'(out_valid), 64'(0));
    chk("post_hs_acc",   64'(out_value), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_digit = 3'b000; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_ready", 64'(in_ready),  64'(1));
    chk("rst_value", 64'(out_value), 64'(0));
    chk("rst_err",   64'(out_err),   64'(0));

    clear_frame(); frame_d[0] = 3'b111;
    send_frame(16, 1'b0, 1'b1);
    chk("neg1_direct", 64'(out_value), 64'hFFFF_FFFF);
    consume(0);

    clear_frame(); frame_d[15] = 3'b110;
    send_frame(16, 1'b1, 1'b1);
    chk("min_direct", 64'(out_value), 64'h8000_0000);
    consume(0);

    clear_frame(); frame_d[0] = 3'b001;
    send_frame(16, 1'b0, 1'b1);
    consume(1);

    clear_frame(); frame_d[0] = 3'b010; frame_d[1] = 3'b001;
    send_frame(2, 1'b1, 1'b1);
    chk("six_direct", 64'(out_value), 64'h6);
    consume(0);

    clear_frame(); frame_d[5] = 3'b011;
    send_frame(16, 1'b0, 1'b1);
    chk("illegal_err", 64'(out_err), 64'(1));
    consume(0);
    clear_frame(); frame_d[3] = 3'b111;
    send_frame(16, 1'b0, 1'b1);
    chk("err_cleared", 64'(out_err), 64'(0));
    consume(3);

    clear_frame(); frame_d[15] = 3'b100;
    send_frame(16, 1'b0, 1'b1);
    consume(0);

    clear_frame();
    for (int i = 0; i < 7; i++) frame_d[i] = 3'b001;
    send_frame(7, 1'b0, 1'b0);
    in_valid = 1'b1; in_digit = 3'b010; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("midrst_valid", 64'(out_valid), 64'(0));
    chk("midrst_ready", 64'(in_ready),  64'(1));
    chk("midrst_value", 64'(out_value), 64'(0));
    chk("midrst_err",   64'(out_err),   64'(0));
    clear_frame(); frame_d[1] = 3'b110; frame_d[2] = 3'b001;
    send_frame(3, 1'b1, 1'b1);
    consume(0);

    for (int f = 0; f < 12; f++) begin
      int n;
      n = $urandom_range(1, ND);
      clear_frame();
      for (int i = 0; i < n; i++) frame_d[i] = 3'($urandom_range(0, 7));
      send_frame(n, (n < ND) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b1);
      consume($urandom_range(0, 2));
    end

    repeat (2) @(posedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
